// File: rtl/uart_console_bridge.sv
// Bus master for the tester-side UART register port: programs divider/enables once,
// then polls RX/TX ready flags and bridges bytes to a pair of valid/ready streams.
module uart_console_bridge #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DIV_ADDR     = 0,
    parameter int unsigned TXEN_ADDR    = 2,
    parameter int unsigned RXEN_ADDR    = 3,
    parameter int unsigned TXDATA_ADDR  = 4,
    parameter int unsigned RXDATA_ADDR  = 5,
    parameter int unsigned TXREADY_ADDR = 6,
    parameter int unsigned RXREADY_ADDR = 7,
    parameter logic [15:0] DIV          = 16'd100,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              init_done,
    output logic              err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StInitDiv,
        StInitTxen,
        StInitRxen,
        StPollRx,
        StRdRx,
        StPush,
        StPollTx,
        StWrTx
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              init_done_q, init_done_d;
    logic              err_q, err_d;

    // Request descriptor for the current state
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_val;
    logic              req_wr;
    logic              req_half;
    logic [1:0]        lane;
    logic              timed_out;
    logic              done;
    logic [7:0]        rd_byte;

    always_comb begin
        req_addr = '0;
        req_val  = '0;
        req_wr   = 1'b0;
        req_half = 1'b0;
        unique case (state_q)
            StInitDiv: begin
                req_addr = ADDR_W'(DIV_ADDR);
                req_val  = DIV;
                req_wr   = 1'b1;
                req_half = 1'b1;
            end
            StInitTxen: begin
                req_addr = ADDR_W'(TXEN_ADDR);
                req_val  = 16'd1;
                req_wr   = 1'b1;
            end
            StInitRxen: begin
                req_addr = ADDR_W'(RXEN_ADDR);
                req_val  = 16'd1;
                req_wr   = 1'b1;
            end
            StPollRx: req_addr = ADDR_W'(RXREADY_ADDR);
            StRdRx:   req_addr = ADDR_W'(RXDATA_ADDR);
            StPollTx: req_addr = ADDR_W'(TXREADY_ADDR);
            StWrTx: begin
                req_addr = ADDR_W'(TXDATA_ADDR);
                req_val  = {8'h00, tx_data};
                req_wr   = 1'b1;
            end
            StPush: req_addr = '0;
        endcase
    end

    assign lane      = req_addr[1:0];
    assign timed_out = valid_q && !uart_ready && (cnt_q == CntW'(TIMEOUT - 1));
    assign done      = valid_q && (uart_ready || timed_out);
    // A timed-out read completes with value 0
    assign rd_byte   = timed_out ? 8'h00 : uart_rdata[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_ready_d  = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;

        if (!valid_q) begin
            if (state_q == StPush) begin
                if (rx_valid_q && rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = StPollTx;
                end
            end else if (state_q == StPollTx && !tx_valid) begin
                state_d = StPollRx;
            end else begin
                valid_d = 1'b1;
                addr_d  = req_addr;
                cnt_d   = '0;
                if (req_wr) begin
                    wdata_d = DATA_W'(req_val) << {lane, 3'b000};
                    wstrb_d = (req_half ? 4'b0011 : 4'b0001) << lane;
                end else begin
                    wdata_d = '0;
                    wstrb_d = 4'b0000;
                end
            end
        end else begin
            if (!uart_ready) cnt_d = cnt_q + 1'b1;
            if (done) begin
                valid_d = 1'b0;
                if (timed_out) err_d = 1'b1;
                unique case (state_q)
                    StInitDiv:  state_d = StInitTxen;
                    StInitTxen: state_d = StInitRxen;
                    StInitRxen: begin
                        state_d     = StPollRx;
                        init_done_d = 1'b1;
                    end
                    StPollRx:   state_d = rd_byte[0] ? StRdRx : StPollTx;
                    StRdRx: begin
                        rx_data_d  = rd_byte;
                        rx_valid_d = 1'b1;
                        state_d    = StPush;
                    end
                    StPollTx:   state_d = (rd_byte[0] && tx_valid) ? StWrTx : StPollRx;
                    StWrTx: begin
                        tx_ready_d = 1'b1;
                        state_d    = StPollRx;
                    end
                    StPush:     state_d = StPush;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInitDiv;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign uart_valid = valid_q;
    assign uart_addr  = addr_q;
    assign uart_wdata = wdata_q;
    assign uart_wstrb = wstrb_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_ready   = tx_ready_q;
    assign init_done  = init_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_console_bridge.sv
// Scoreboard bench for uart_console_bridge: a UART register slave model answers the bus,
// a monitor checks every bus request and RX handshake against queued expectations.
module tb_uart_console_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_valid;
    logic [15:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        init_done;
    logic        err;

    uart_console_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .init_done  (init_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_rx[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_rd6    = 0;
    int n_rd7    = 0;
    int n_txr    = 0;

    // Slave model knobs
    int          latency = 0;
    bit          dead    = 1'b0;
    bit          rx_flag = 1'b0;
    bit          tx_flag = 1'b0;
    logic [31:0] rx_word = 32'hA5B6_41C3;
    int          wcnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_t e;
        e.addr  = a;
        e.wdata = d;
        e.wstrb = s;
        exp_bus.push_back(e);
    endtask

    task automatic push_init();
        push_bus(16'd0, 32'h0000_0064, 4'b0011);
        push_bus(16'd2, 32'h0001_0000, 4'b0100);
        push_bus(16'd3, 32'h0100_0000, 4'b1000);
    endtask

    // UART register slave: ready after 'latency' wait cycles, never when dead
    always @(posedge clk) begin
        #2;
        if (uart_valid && !dead) begin
            if (wcnt >= latency) begin
                uart_ready = 1'b1;
                wcnt       = 0;
                case (uart_addr)
                    16'd7:   uart_rdata = {7'd0, rx_flag, 24'd0};
                    16'd6:   uart_rdata = {15'd0, tx_flag, 16'd0};
                    16'd5:   uart_rdata = rx_word;
                    default: uart_rdata = 32'hDEAD_BEEF;
                endcase
            end else begin
                uart_ready = 1'b0;
                uart_rdata = 32'h0;
                wcnt++;
            end
        end else begin
            uart_ready = 1'b0;
            uart_rdata = 32'h0;
            wcnt       = 0;
        end
    end

    // Monitor: samples on the falling edge, between input updates and the active edge
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    always @(negedge clk) begin
        bus_t e;
        if (uart_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_starts++;
            if (uart_addr == 16'd6 && uart_wstrb == 4'b0000) n_rd6++;
            else if (uart_addr == 16'd7 && uart_wstrb == 4'b0000) n_rd7++;
            else if (exp_bus.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected: got addr 0x%04h wdata 0x%08h wstrb %b, expected none",
                         uart_addr, uart_wdata, uart_wstrb);
            end else begin
                e = exp_bus.pop_front();
                chk("bus_addr", {16'd0, uart_addr}, {16'd0, e.addr});
                chk("bus_wdata", uart_wdata, e.wdata);
                chk("bus_wstrb", {28'd0, uart_wstrb}, {28'd0, e.wstrb});
            end
        end
        if (prev_hs) chk("bus_gap_after_ready", {31'd0, uart_valid}, 32'd0);
        if (tx_ready === 1'b1) n_txr++;
        if (rx_valid === 1'b1 && rx_ready) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%02h, expected none", rx_data);
            end else begin
                chk("rx_data_hs", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
        prev_hs    = (uart_valid === 1'b1) && uart_ready;
        prev_valid = uart_valid;
    end

    initial begin
        int n;
        int s;
        int hi;
        int r6;
        int r7;
        int t0;

        rst_n      = 1'b0;
        uart_ready = 1'b0;
        uart_rdata = 32'h0;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        repeat (3) tick();
        chk("reset_ctrl", {15'd0, uart_valid, uart_wstrb, rx_data, rx_valid, tx_ready, init_done, err},
            32'd0);
        chk("reset_addr", {16'd0, uart_addr}, 32'd0);
        chk("reset_wdata", uart_wdata, 32'd0);

        // Zero-wait slave: init_done lands exactly on cycle 6
        latency = 0;
        push_init();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("init_done_cycle5", {31'd0, init_done}, 32'd0);
        tick();
        chk("init_done_cycle6", {31'd0, init_done}, 32'd1);
        chk("init_queue_drained", exp_bus.size(), 32'd0);

        // RX byte with consumer backpressure
        latency = 1;
        push_bus(16'd5, 32'h0, 4'b0000);
        exp_rx.push_back(8'h41);
        rx_flag = 1'b1;
        n = 0;
        while (!rx_valid && n < 200) begin
            tick();
            n++;
        end
        chk("rx_valid_rise", {31'd0, rx_valid}, 32'd1);
        rx_flag = 1'b0;
        s  = n_starts;
        hi = 0;
        repeat (20) begin
            tick();
            if (rx_valid) hi++;
        end
        chk("rx_hold_cycles", hi, 32'd20);
        chk("rx_hold_no_bus", n_starts - s, 32'd0);
        chk("rx_data_held", {24'd0, rx_data}, 32'h41);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_valid_cleared", {31'd0, rx_valid}, 32'd0);
        s = n_starts;
        repeat (30) tick();
        chk("poll_resumed", {31'd0, n_starts > s}, 32'd1);

        // TX byte with TXREADY set
        tx_flag  = 1'b1;
        tx_data  = 8'h05;
        tx_valid = 1'b1;
        push_bus(16'd4, 32'h0000_0005, 4'b0001);
        t0 = n_txr;
        n  = 0;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        chk("tx_ready_seen", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (5) tick();
        chk("tx_ready_pulses", n_txr - t0, 32'd1);
        chk("tx_write_seen", exp_bus.size(), 32'd0);

        // TXREADY clear: polls repeat, no write
        tx_flag  = 1'b0;
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        r6 = n_rd6;
        t0 = n_txr;
        repeat (60) tick();
        chk("txrdy0_polls", {31'd0, n_rd6 > r6}, 32'd1);
        chk("txrdy0_no_pulse", n_txr - t0, 32'd0);
        tx_valid = 1'b0;

        // No TX offered: only RXREADY polls
        repeat (5) tick();
        r6 = n_rd6;
        r7 = n_rd7;
        repeat (60) tick();
        chk("idle_no_txpoll", n_rd6 - r6, 32'd0);
        chk("idle_rxpoll", {31'd0, n_rd7 > r7}, 32'd1);

        // Dead slave on the divider write
        rst_n = 1'b0;
        repeat (2) tick();
        dead = 1'b1;
        push_init();
        rst_n = 1'b1;
        n = 0;
        while (!uart_valid && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (uart_valid && n < 400) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 32'd255);
        chk("err_set", {31'd0, err}, 32'd1);
        dead    = 1'b0;
        latency = 1;
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        chk("init_after_timeout", {31'd0, init_done}, 32'd1);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("timeout_queue_drained", exp_bus.size(), 32'd0);

        // Reset in the middle of a TX data write
        tx_flag  = 1'b1;
        latency  = 6;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        push_bus(16'd4, 32'h0000_003C, 4'b0001);
        n = 0;
        while (!(uart_valid && uart_addr == 16'd4) && n < 300) begin
            tick();
            n++;
        end
        chk("wrtx_started", {31'd0, uart_valid && uart_addr == 16'd4}, 32'd1);
        t0       = n_txr;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tick();
        chk("midreset_ctrl",
            {15'd0, uart_valid, uart_wstrb, rx_data, rx_valid, tx_ready, init_done, err}, 32'd0);
        chk("midreset_addr", {16'd0, uart_addr}, 32'd0);
        chk("midreset_wdata", uart_wdata, 32'd0);
        tick();
        latency = 1;
        push_init();
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        chk("reinit_done", {31'd0, init_done}, 32'd1);
        chk("reinit_err_clear", {31'd0, err}, 32'd0);
        chk("no_tx_pulse_after_reset", n_txr - t0, 32'd0);
        chk("reinit_queue_drained", exp_bus.size(), 32'd0);
        chk("rx_queue_drained", exp_rx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
